// File: rtl/ttm4_pkg.sv
`default_nettype none
//==== ttm4_pkg : shared encodings for the stack sequencer and its helpers | rev 1.0 ====

package ttm4_pkg;

  localparam int NIB_W = 4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PUSH_WR   = 3'd1;
  localparam logic [2:0] S_PUSH_STEP = 3'd2;
  localparam logic [2:0] S_POP_STEP  = 3'd3;
  localparam logic [2:0] S_POP_RD    = 3'd4;
  localparam logic [2:0] S_FIN       = 3'd5;

  // SP_D_nU polarity: pushes walk the stack downwards.
  localparam logic DIR_DOWN = 1'b1;
  localparam logic DIR_UP   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/stack_seq_if.sv
`default_nettype none
//==== stack_seq_if : decoder request bus plus SP / stack-RAM strobes | rev 1.0 ====

interface stack_seq_if
  import ttm4_pkg::*;
#(
  parameter int NIB        = 3,
  parameter int MAX_FRAMES = 4,
  parameter int SP_W       = 8
);

  localparam int DEPTH_W = $clog2(MAX_FRAMES + 1);

  logic                   REQ_PUSH;
  logic                   REQ_POP;
  logic [NIB_W*NIB-1:0]   PUSH_DATA;
  logic [NIB_W*NIB-1:0]   POP_DATA;
  logic                   BUSY;
  logic                   DONE;
  logic                   ERR_OVF;
  logic                   ERR_UDF;
  logic [DEPTH_W-1:0]     DEPTH;
  logic                   nSK_EN;
  logic                   SP_D_nU;
  logic                   SPC;
  logic [SP_W-1:0]        SP_IN;
  logic [NIB_W-1:0]       STORE_OUT;
  logic                   nSTORE_WE;
  logic [NIB_W-1:0]       STORE_IN;

  modport master (
    output REQ_PUSH, REQ_POP, PUSH_DATA, SP_IN, STORE_IN,
    input  POP_DATA, BUSY, DONE, ERR_OVF, ERR_UDF, DEPTH,
           nSK_EN, SP_D_nU, SPC, STORE_OUT, nSTORE_WE
  );

  modport slave (
    input  REQ_PUSH, REQ_POP, PUSH_DATA, SP_IN, STORE_IN,
    output POP_DATA, BUSY, DONE, ERR_OVF, ERR_UDF, DEPTH,
           nSK_EN, SP_D_nU, SPC, STORE_OUT, nSTORE_WE
  );

endinterface

`default_nettype wire

// File: rtl/stack_depth_cnt.sv
`default_nettype none
//==== stack_depth_cnt : saturating up/down frame counter 0..MAX_COUNT | rev 1.0 ====

module stack_depth_cnt #(
  parameter int MAX_COUNT = 4,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign full  = (count_q == CNT_W'(MAX_COUNT));
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !inc && !empty) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stack_seq.sv
`default_nettype none
//==== stack_seq : SP strobe and nibble-RAM sequencer for CALL/RET frame push/pop | rev 1.0 ====

module stack_seq
  import ttm4_pkg::*;
#(
  parameter int NIB        = 3,
  parameter int MAX_FRAMES = 4,
  parameter int SP_W       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  stack_seq_if.slave bus
);

  localparam int DEPTH_W = $clog2(MAX_FRAMES + 1);
  localparam int FRAME_W = NIB_W * NIB;
  localparam int K_W     = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NIB - 1);

  logic [2:0]         state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] pop_data_q, pop_data_d;
  logic [NIB_W-1:0]   store_out_q, store_out_d;
  logic               sk_en_n_q, sk_en_n_d;
  logic               sp_dir_q, sp_dir_d;
  logic               spc_n_q, spc_n_d;
  logic               store_we_n_q, store_we_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_udf_q, err_udf_d;

  logic               depth_inc, depth_dec, depth_full, depth_empty;
  logic [DEPTH_W-1:0] depth;

  // SP value is only routed to the debug mux outside this block.
  logic [SP_W-1:0]    sp_in_unused;
  assign sp_in_unused = bus.SP_IN;

  stack_depth_cnt #(
    .MAX_COUNT (MAX_FRAMES)
  ) u_depth (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (depth_inc),
    .dec   (depth_dec),
    .count (depth),
    .full  (depth_full),
    .empty (depth_empty)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    shift_d    = shift_q;
    pop_data_d = pop_data_q;
    err_ovf_d  = err_ovf_q;
    err_udf_d  = err_udf_q;
    depth_inc  = 1'b0;
    depth_dec  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.REQ_PUSH) begin
          if (depth_full) begin
            state_d   = S_FIN;
            err_ovf_d = 1'b1;
          end else begin
            state_d = S_PUSH_WR;
            k_d     = K_LAST;
          end
        end else if (bus.REQ_POP) begin
          if (depth_empty) begin
            state_d   = S_FIN;
            err_udf_d = 1'b1;
          end else begin
            state_d = S_POP_STEP;
            k_d     = '0;
          end
        end
      end
      S_PUSH_WR: state_d = S_PUSH_STEP;
      S_PUSH_STEP: begin
        if (k_q != '0) begin
          k_d     = k_q - K_W'(1);
          state_d = S_PUSH_WR;
        end else begin
          depth_inc = 1'b1;
          err_udf_d = 1'b0;
          state_d   = S_FIN;
        end
      end
      S_POP_STEP: state_d = S_POP_RD;
      S_POP_RD: begin
        // LS nibble sits nearest the top of stack, so it is read first.
        shift_d[int'(k_q)*NIB_W +: NIB_W] = bus.STORE_IN;
        if (k_q != K_LAST) begin
          k_d     = k_q + K_W'(1);
          state_d = S_POP_STEP;
        end else begin
          pop_data_d = shift_d;
          depth_dec  = 1'b1;
          err_ovf_d  = 1'b0;
          state_d    = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they register alongside it.
  always_comb begin
    sk_en_n_d    = !((state_d == S_PUSH_WR)  || (state_d == S_PUSH_STEP) ||
                     (state_d == S_POP_STEP) || (state_d == S_POP_RD));
    spc_n_d      = !((state_d == S_PUSH_STEP) || (state_d == S_POP_STEP));
    store_we_n_d = (state_d != S_PUSH_WR);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
    store_out_d  = store_out_q;
    if (state_d == S_PUSH_WR) begin
      store_out_d = bus.PUSH_DATA[int'(k_d)*NIB_W +: NIB_W];
    end
    sp_dir_d = sp_dir_q;
    if (state_d == S_PUSH_STEP) begin
      sp_dir_d = DIR_DOWN;
    end else if (state_d == S_POP_STEP) begin
      sp_dir_d = DIR_UP;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      shift_q      <= '0;
      pop_data_q   <= '0;
      store_out_q  <= '0;
      sk_en_n_q    <= 1'b1;
      sp_dir_q     <= DIR_UP;
      spc_n_q      <= 1'b1;
      store_we_n_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_udf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      shift_q      <= shift_d;
      pop_data_q   <= pop_data_d;
      store_out_q  <= store_out_d;
      sk_en_n_q    <= sk_en_n_d;
      sp_dir_q     <= sp_dir_d;
      spc_n_q      <= spc_n_d;
      store_we_n_q <= store_we_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_ovf_q    <= err_ovf_d;
      err_udf_q    <= err_udf_d;
    end
  end

  assign bus.POP_DATA  = pop_data_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR_OVF   = err_ovf_q;
  assign bus.ERR_UDF   = err_udf_q;
  assign bus.DEPTH     = depth;
  assign bus.nSK_EN    = sk_en_n_q;
  assign bus.SP_D_nU   = sp_dir_q;
  assign bus.SPC       = spc_n_q;
  assign bus.STORE_OUT = store_out_q;
  assign bus.nSTORE_WE = store_we_n_q;

endmodule

`default_nettype wire
